mvu_apb_cfg_sequencer: RTL and testbench

- APB master that turns a valid/ready stream of CSR write requests {address, data} into APB3 write transfers into the MVU APB configuration slave.
- Sits directly upstream of that slave, between the host/controller command FIFO and the MVU array.
- Keeps a per-MVU busy bitmap: set when a COMMAND CSR write completes, cleared by the MVU completion interrupt.
- Holds off any CSR write to an MVU that is still running, so configuration is never changed mid-job.

---
 rtl/mvu_apb_cfg_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_mvu_apb_cfg_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_apb_cfg_sequencer.sv
// APB3 write master that feeds CSR write requests into the MVU configuration slave,
// tracking per-MVU busy state. Optional ACCESS-phase timeout: define APB_SEQ_TIMEOUT_EN.

package mvu_pkg;
  localparam logic [11:0] CSR_MVUCOMMAND = 12'h040;
endpackage

module mvu_apb_cfg_sequencer #(
  parameter int          NMVU           = 8,
  parameter int          APB_ADDR_WIDTH = 15,
  parameter int          DATA_W         = 32,
  parameter logic [11:0] CSR_CMD_ADDR   = mvu_pkg::CSR_MVUCOMMAND,
  parameter int          TIMEOUT        = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_W-1:0]         req_data,
  input  logic [NMVU-1:0]           mvu_irq,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic                      pready,
  input  logic                      pslverr,
  output logic [NMVU-1:0]           mvu_busy,
  output logic                      err,
  input  logic                      err_clr,
  output logic [15:0]               cmd_cnt
);

  localparam int IDW = APB_ADDR_WIDTH - 12;

  if (NMVU < 2 || APB_ADDR_WIDTH != 12 + $clog2(NMVU)) begin : g_bad_addr_width
    $error("APB_ADDR_WIDTH must equal 12 + clog2(NMVU) with NMVU >= 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, HOLD, SETUP, ACCESS} state_e;

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]         data_q, data_d;
  logic [NMVU-1:0]           busy_q, busy_d;
  logic                      err_q, err_d;
  logic [15:0]               cnt_q, cnt_d;
  logic                      req_ready_q, psel_q, penable_q;

  logic [IDW-1:0]  id;
  logic            idValid;
  logic            idBusy;
  logic [NMVU-1:0] idOneHot;
  logic            isCmd;
  logic            xferDone;
  logic            timeoutHit;

  // Decode the held request's MVU; ids beyond NMVU match nothing and are flagged.
  always_comb begin
    id       = addr_q[APB_ADDR_WIDTH-1:12];
    idValid  = 1'b0;
    idBusy   = 1'b0;
    idOneHot = '0;
    for (int k = 0; k < NMVU; k++) begin
      if (id == IDW'(k)) begin
        idValid     = 1'b1;
        idBusy      = busy_q[k];
        idOneHot[k] = 1'b1;
      end
    end
  end

  assign isCmd    = (addr_q[11:0] == CSR_CMD_ADDR);
  assign xferDone = (state_q == ACCESS) && pready;

`ifdef APB_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_q, tmo_d;

  assign timeoutHit = (state_q == ACCESS) && !pready && (tmo_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_d == SETUP) begin
      tmo_d = '0;
    end else if (state_q == ACCESS) begin
      tmo_d = tmo_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          data_d  = req_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!idBusy) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready || timeoutHit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A completing command sets busy after the irq clear is applied, so the set wins.
  always_comb begin
    busy_d = busy_q & ~mvu_irq;
    cnt_d  = cnt_q;
    err_d  = err_q & ~err_clr;
    if (xferDone) begin
      if (pslverr || !idValid) begin
        err_d = 1'b1;
      end else if (isCmd) begin
        busy_d = busy_d | idOneHot;
        cnt_d  = cnt_q + 16'd1;
      end
    end
    if (timeoutHit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == IDLE);
      psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q   <= (state_d == ACCESS);
    end
  end

  assign req_ready = req_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = 1'b1;
  assign paddr     = addr_q;
  assign pwdata    = data_q;
  assign mvu_busy  = busy_q;
  assign err       = err_q;
  assign cmd_cnt   = cnt_q;

endmodule

// File: tb/tb_mvu_apb_cfg_sequencer.sv
// Randomized self-checking bench for mvu_apb_cfg_sequencer with a transaction-level
// model of busy bitmap, sticky error and command count.

module tb_mvu_apb_cfg_sequencer;

  localparam int NMVU = 8;
  localparam int AW   = 15;
  localparam int DW   = 32;
`ifdef APB_SEQ_TIMEOUT_EN
  localparam int TMO  = 16;
`else
  localparam int TMO  = 256;
`endif
  localparam logic [11:0] CMD = mvu_pkg::CSR_MVUCOMMAND;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [AW-1:0]   req_addr = '0;
  logic [DW-1:0]   req_data = '0;
  logic [NMVU-1:0] mvu_irq = '0;
  logic [AW-1:0]   paddr;
  logic            psel, penable, pwrite;
  logic [DW-1:0]   pwdata;
  logic            pready = 1'b0;
  logic            pslverr = 1'b0;
  logic [NMVU-1:0] mvu_busy;
  logic            err;
  logic            err_clr = 1'b0;
  logic [15:0]     cmd_cnt;

  int nTests = 0;
  int nFail  = 0;

  logic [NMVU-1:0] mBusy = '0;
  logic            mErr  = 1'b0;
  logic [15:0]     mCnt  = '0;

  mvu_apb_cfg_sequencer #(
    .NMVU(NMVU), .APB_ADDR_WIDTH(AW), .DATA_W(DW),
    .CSR_CMD_ADDR(CMD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .mvu_irq(mvu_irq),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .pslverr(pslverr),
    .mvu_busy(mvu_busy), .err(err), .err_clr(err_clr), .cmd_cnt(cmd_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present a request in IDLE and step into HOLD.
  task automatic issue(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    nTests++;
    if (req_ready !== 1'b1) begin
      nFail++; $display("[TB] FAIL issue_ready: req_ready=%b expected 1", req_ready);
    end
    req_valid = 1'b1; req_addr = addr; req_data = data;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom(); req_data = $urandom();
    nTests++;
    if (psel !== 1'b0 || req_ready !== 1'b0) begin
      nFail++; $display("[TB] FAIL hold: psel=%b req_ready=%b expected 0 0", psel, req_ready);
    end
  endtask

  // Starting in the SETUP cycle: check the APB phases, complete the write, update the model.
  task automatic finishAccess(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input int nWait, input logic slverr,
                              input logic [NMVU-1:0] irqDone, input logic clrDone);
    int id;
    id = int'(addr[AW-1:12]);
    nTests++;
    if (psel !== 1'b1 || penable !== 1'b0 || paddr !== addr || pwdata !== data) begin
      nFail++;
      $display("[TB] FAIL setup: psel=%b penable=%b paddr=%h pwdata=%h expected 1 0 %h %h",
               psel, penable, paddr, pwdata, addr, data);
    end
    @(negedge clk);
    nTests++;
    if (psel !== 1'b1 || penable !== 1'b1 || pwrite !== 1'b1 || paddr !== addr || pwdata !== data) begin
      nFail++;
      $display("[TB] FAIL access: psel=%b penable=%b pwrite=%b paddr=%h expected 1 1 1 %h",
               psel, penable, pwrite, paddr, addr);
    end
    if (nWait == 0) begin
      pready = 1'b1; pslverr = slverr; mvu_irq = irqDone; err_clr = clrDone;
    end
    for (int w = 0; w < nWait; w++) begin
      @(negedge clk);
      nTests++;
      if (psel !== 1'b1 || penable !== 1'b1 || paddr !== addr || pwdata !== data) begin
        nFail++;
        $display("[TB] FAIL wait_state: psel=%b penable=%b paddr=%h expected 1 1 %h",
                 psel, penable, paddr, addr);
      end
      if (w == nWait - 1) begin
        pready = 1'b1; pslverr = slverr; mvu_irq = irqDone; err_clr = clrDone;
      end
    end
    @(negedge clk);
    pready = 1'b0; pslverr = 1'b0; mvu_irq = '0; err_clr = 1'b0;
    mBusy = mBusy & ~irqDone;
    if (addr[11:0] == CMD && !slverr && id < NMVU) begin
      mBusy[id] = 1'b1;
      mCnt = mCnt + 16'd1;
    end
    mErr = (mErr && !clrDone) || slverr || (id >= NMVU);
    nTests++;
    if (psel !== 1'b0 || penable !== 1'b0 || req_ready !== 1'b1 || mvu_busy !== mBusy ||
        err !== mErr || cmd_cnt !== mCnt) begin
      nFail++;
      $display("[TB] FAIL complete: psel=%b penable=%b ready=%b busy=%h err=%b cnt=%0d expected 0 0 1 %h %b %0d",
               psel, penable, req_ready, mvu_busy, err, cmd_cnt, mBusy, mErr, mCnt);
    end
  endtask

  task automatic writeTxn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int nWait, input logic slverr,
                          input logic [NMVU-1:0] irqDone, input logic clrDone);
    issue(addr, data);
    @(negedge clk);
    finishAccess(addr, data, nWait, slverr, irqDone, clrDone);
  endtask

  task automatic pulseIrq(input logic [NMVU-1:0] irq);
    mvu_irq = irq;
    @(negedge clk);
    mvu_irq = '0;
    mBusy = mBusy & ~irq;
    nTests++;
    if (mvu_busy !== mBusy) begin
      nFail++; $display("[TB] FAIL irq_clear: busy=%h expected %h", mvu_busy, mBusy);
    end
  endtask

  task automatic pulseErrClr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    mErr = 1'b0;
    nTests++;
    if (err !== 1'b0) begin
      nFail++; $display("[TB] FAIL err_clr: err=%b expected 0", err);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    nTests++;
    if (req_ready !== 1'b0 || psel !== 1'b0 || penable !== 1'b0 || paddr !== '0 || pwdata !== '0 ||
        mvu_busy !== '0 || err !== 1'b0 || cmd_cnt !== 16'd0 || pwrite !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL reset_values: ready=%b psel=%b pen=%b paddr=%h pwdata=%h busy=%h err=%b cnt=%0d pwrite=%b",
               req_ready, psel, penable, paddr, pwdata, mvu_busy, err, cmd_cnt, pwrite);
    end
    rst_n = 1'b1;
    @(negedge clk);
    nTests++;
    if (req_ready !== 1'b1) begin
      nFail++; $display("[TB] FAIL reset_release: req_ready=%b expected 1", req_ready);
    end
  endtask

  task automatic test_single_write();
    writeTxn(15'h0010, 32'h0000_00A5, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_command_launch();
    logic [AW-1:0] a;
    a = {3'd3, CMD};
    writeTxn(a, 32'h1, 0, 1'b0, '0, 1'b0);
    nTests++;
    if (mvu_busy !== 8'h08 || cmd_cnt !== 16'd1) begin
      nFail++; $display("[TB] FAIL cmd_launch: busy=%h cnt=%0d expected 08 1", mvu_busy, cmd_cnt);
    end
    a = {3'd3, 12'h020};
    issue(a, 32'hCAFE_0003);
    repeat (3) begin
      @(negedge clk);
      nTests++;
      if (psel !== 1'b0 || mvu_busy !== 8'h08) begin
        nFail++; $display("[TB] FAIL stall: psel=%b busy=%h expected 0 08", psel, mvu_busy);
      end
    end
    pulseIrq(8'h08);
    nTests++;
    if (psel !== 1'b0) begin
      nFail++; $display("[TB] FAIL release_latency: psel=%b expected 0", psel);
    end
    @(negedge clk);
    finishAccess(a, 32'hCAFE_0003, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_independent();
    writeTxn({3'd3, CMD}, 32'h2, 0, 1'b0, '0, 1'b0);
    writeTxn({3'd5, 12'h004}, 32'h5555_0005, 0, 1'b0, '0, 1'b0);
    nTests++;
    if (mvu_busy !== 8'h08) begin
      nFail++; $display("[TB] FAIL independent: busy=%h expected 08", mvu_busy);
    end
  endtask

  task automatic test_wait_error();
    writeTxn({3'd1, CMD}, 32'h1111_0001, 5, 1'b1, '0, 1'b0);
    nTests++;
    if (err !== 1'b1 || mvu_busy !== 8'h08 || cmd_cnt !== 16'd2) begin
      nFail++; $display("[TB] FAIL slverr: err=%b busy=%h cnt=%0d expected 1 08 2", err, mvu_busy, cmd_cnt);
    end
    pulseErrClr();
    writeTxn({3'd4, 12'h008}, 32'h4444_0004, 1, 1'b1, '0, 1'b1);
    nTests++;
    if (err !== 1'b1) begin
      nFail++; $display("[TB] FAIL clr_vs_set: err=%b expected 1", err);
    end
    pulseErrClr();
  endtask

  task automatic test_simul_irq();
    writeTxn({3'd2, CMD}, 32'h2222_0002, 0, 1'b0, 8'h04, 1'b0);
    nTests++;
    if (mvu_busy[2] !== 1'b1) begin
      nFail++; $display("[TB] FAIL set_wins: busy[2]=%b expected 1", mvu_busy[2]);
    end
    pulseIrq(8'h04);
    pulseIrq(8'h40);
  endtask

  task automatic test_long_wait();
`ifdef APB_SEQ_TIMEOUT_EN
    issue({3'd6, 12'h00C}, 32'h6666_0006);
    @(negedge clk);
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      nTests++;
      if (psel !== 1'b1 || penable !== 1'b1) begin
        nFail++; $display("[TB] FAIL tmo_access: cycle %0d psel=%b penable=%b expected 1 1", i, psel, penable);
      end
    end
    @(negedge clk);
    mErr = 1'b1;
    nTests++;
    if (psel !== 1'b0 || penable !== 1'b0 || err !== 1'b1 || req_ready !== 1'b1 ||
        mvu_busy !== mBusy || cmd_cnt !== mCnt) begin
      nFail++;
      $display("[TB] FAIL timeout: psel=%b pen=%b err=%b ready=%b busy=%h cnt=%0d expected 0 0 1 1 %h %0d",
               psel, penable, err, req_ready, mvu_busy, cmd_cnt, mBusy, mCnt);
    end
    pulseErrClr();
`else
    writeTxn({3'd6, 12'h00C}, 32'h6666_0006, 20, 1'b0, '0, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic [2:0]      id;
    logic [11:0]     off;
    logic [NMVU-1:0] irqDone;
    for (int n = 0; n < 60; n++) begin
      id  = 3'($urandom_range(0, NMVU - 1));
      off = 12'($urandom());
      if ($urandom_range(0, 2) == 0) off = CMD;
      else if (off == CMD) off = off ^ 12'h1;
      if (mBusy[id]) pulseIrq(8'(1 << id) | (($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00));
      irqDone = ($urandom_range(0, 4) == 0) ? 8'($urandom()) : 8'h00;
      writeTxn({id, off}, DW'($urandom()), $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
               irqDone, ($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_reset_mid();
    writeTxn({3'd3, CMD}, 32'h3, 0, 1'b0, '0, 1'b0);
    issue({3'd6, 12'h010}, 32'h7777_0007);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    mBusy = '0; mErr = 1'b0; mCnt = '0;
    nTests++;
    if (psel !== 1'b0 || penable !== 1'b0 || mvu_busy !== '0 || cmd_cnt !== 16'd0 ||
        paddr !== '0 || req_ready !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_mid: psel=%b pen=%b busy=%h cnt=%0d paddr=%h ready=%b expected all 0",
               psel, penable, mvu_busy, cmd_cnt, paddr, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    writeTxn({3'd0, 12'h100}, 32'h0BAD_F00D, 0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_command_launch();
    test_independent();
    test_wait_error();
    test_simul_irq();
    test_long_wait();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
